// File: rtl/multdiv_seq.sv
// Iterative signed 32-bit multiply (radix-4 Booth) / divide (restoring) unit.
// A single 32-bit cla_outer adder is time-shared across all add/subtract steps.

module cla_outer (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    // 4-bit lookahead groups; the group carry-out feeds the next group
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int unsigned k = 0; k < 8; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
        sum  = p ^ c[31:0];
        cout = c[32];
    end
endmodule

module multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(WIDTH / 2);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(WIDTH);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   counter;
    logic [WIDTH+1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               q_prev;
    logic [WIDTH-1:0]   mcand;
    logic               neg_q;
    logic               div_zero;
    logic               div_exc;

    logic               start;
    logic               mult_last;
    logic               div_last;
    logic [WIDTH+1:0]   booth_add;
    logic [WIDTH+1:0]   booth_b;
    logic               booth_neg;
    logic [WIDTH-1:0]   div_s;
    logic [WIDTH-1:0]   cla_a;
    logic [WIDTH-1:0]   cla_b;
    logic               cla_cin;
    logic [WIDTH-1:0]   cla_sum;
    logic               cla_cout;
    logic [1:0]         hi_ext;
    logic [WIDTH:0]     p_hi;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign mult_last = (state_q == S_MULT) && (counter == MULT_LAST);
    assign div_last  = (state_q == S_DIV) && (counter == DIV_LAST);
    assign div_s     = {hi[WIDTH-2:0], lo[WIDTH-1]};
    assign p_hi      = {hi[WIDTH-1:0], lo[WIDTH-1]};

    assign data_resultRDY = (state_q == S_DONE);
    assign busy           = (state_q != S_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ctrl_MULT ? S_MULT : S_DIV;
        end else begin
            case (state_q)
                S_MULT:  if (mult_last) state_d = S_DONE;
                S_DIV:   if (div_last) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        booth_add = '0;
        booth_neg = 1'b0;
        case ({lo[1:0], q_prev})
            3'b001, 3'b010: booth_add = {{2{mcand[WIDTH-1]}}, mcand};
            3'b011:         booth_add = {mcand[WIDTH-1], mcand, 1'b0};
            3'b100: begin
                booth_add = {mcand[WIDTH-1], mcand, 1'b0};
                booth_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                booth_add = {{2{mcand[WIDTH-1]}}, mcand};
                booth_neg = 1'b1;
            end
            default: booth_add = '0;
        endcase
        booth_b = booth_neg ? ~booth_add : booth_add;
    end

    // Adder ownership: a start pulse takes it for |A|, then the active op owns it.
    // For division, adding B itself when B<0 is the same as subtracting |B|.
    always_comb begin
        cla_a   = '0;
        cla_b   = '0;
        cla_cin = 1'b0;
        if (start) begin
            cla_a   = data_operandA[WIDTH-1] ? ~data_operandA : data_operandA;
            cla_cin = data_operandA[WIDTH-1];
        end else if (state_q == S_MULT) begin
            cla_a   = hi[WIDTH-1:0];
            cla_b   = booth_b[WIDTH-1:0];
            cla_cin = booth_neg;
        end else if (state_q == S_DIV) begin
            if (div_last) begin
                cla_a   = neg_q ? ~lo : lo;
                cla_cin = neg_q;
            end else begin
                cla_a   = div_s;
                cla_b   = mcand[WIDTH-1] ? mcand : ~mcand;
                cla_cin = ~mcand[WIDTH-1];
            end
        end
        hi_ext = hi[WIDTH+1:WIDTH] + booth_b[WIDTH+1:WIDTH] + {1'b0, cla_cout};
    end

    cla_outer u_cla (
        .a    (cla_a),
        .b    (cla_b),
        .cin  (cla_cin),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter        <= '0;
            hi             <= '0;
            lo             <= '0;
            q_prev         <= 1'b0;
            mcand          <= '0;
            neg_q          <= 1'b0;
            div_zero       <= 1'b0;
            div_exc        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            counter <= '0;
            hi      <= '0;
            q_prev  <= 1'b0;
            if (ctrl_MULT) begin
                lo    <= data_operandB;
                mcand <= data_operandA;
            end else begin
                lo       <= cla_sum;
                mcand    <= data_operandB;
                neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero <= (data_operandB == '0);
                div_exc  <= (data_operandB == '0) ||
                            ((data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1));
            end
        end else begin
            case (state_q)
                S_MULT: begin
                    if (mult_last) begin
                        data_result    <= lo;
                        data_exception <= ~((&p_hi) | ~(|p_hi));
                    end else begin
                        hi      <= {hi_ext[1], hi_ext[1], hi_ext, cla_sum[WIDTH-1:2]};
                        lo      <= {cla_sum[1:0], lo[WIDTH-1:2]};
                        q_prev  <= lo[1];
                        counter <= counter + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (div_last) begin
                        data_result    <= div_zero ? '0 : cla_sum;
                        data_exception <= div_exc;
                    end else begin
                        hi      <= {2'b00, (cla_cout ? cla_sum : div_s)};
                        lo      <= {lo[WIDTH-2:0], cla_cout};
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: counter <= counter;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq: expected results queued at issue, checked when RDY pulses.

module tb_multdiv_seq;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int unsigned at;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          n_asrt = 0;
    int          n_fail = 0;

    multdiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic exc);
        logic signed [63:0] p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [32:0]        top;
        sa = a;
        sb = b;
        if (is_mult) begin
            p   = 64'(sa) * 64'(sb);
            res = p[31:0];
            top = p[63:31];
            exc = !((&top) || !(|top));
        end else if (b == 32'h0) begin
            res = 32'h0;
            exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'h8000_0000;
            exc = 1'b1;
        end else begin
            res = sa / sb;
            exc = 1'b0;
        end
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (data_resultRDY) begin
            if (exp_q.size() == 0) begin
                check("rdy_unexpected", {31'b0, data_resultRDY}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("rdy_cycle", cyc, e.at);
                check("result", data_result, e.res);
                check("exception", {31'b0, data_exception}, {31'b0, e.exc});
            end
        end
    end

    // Start edge E is the posedge after the drive; returns at E+#1.
    task automatic start_op(input logic do_mult, input logic do_div,
                            input logic [31:0] a, input logic [31:0] b, input bit abort);
        exp_t e;
        @(negedge clock);
        ctrl_MULT     = do_mult;
        ctrl_DIV      = do_div;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        if (abort) exp_q.delete();
        model(do_mult, a, b, e.res, e.exc);
        e.at = cyc + (do_mult ? 32'd17 : 32'd33);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        int unsigned i = 0;
        while (exp_q.size() != 0 && i < 60) begin
            @(posedge clock);
            i++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        #1 reset = 1'b0;
        #2;
        check("rst_result", data_result, 32'h0);
        check("rst_exc", {31'b0, data_exception}, 32'h0);
        check("rst_rdy", {31'b0, data_resultRDY}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        @(negedge clock) reset = 1'b1;

        // multiply latency and busy window
        start_op(1'b1, 1'b0, 32'd7, -32'sd6, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clock);
            #1 check($sformatf("busy_E+%0d", k), {31'b0, busy}, 32'h1);
        end
        @(posedge clock);
        #1 check("busy_E+18", {31'b0, busy}, 32'h0);
        wait_drain();

        start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0);
        wait_drain();
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_drain();
        start_op(1'b0, 1'b1, -32'sd100, 32'd7, 1'b0);
        wait_drain();
        start_op(1'b0, 1'b1, 32'd100, -32'sd7, 1'b0);
        wait_drain();
        start_op(1'b0, 1'b1, 32'd5, 32'd0, 1'b0);
        wait_drain();
        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_drain();
        // both strobes at once: multiply wins
        start_op(1'b1, 1'b1, -32'sd3, 32'd5, 1'b0);
        wait_drain();

        // restart mid-multiply with a divide
        start_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b0);
        repeat (4) @(posedge clock);
        start_op(1'b0, 1'b1, 32'd20, 32'd3, 1'b1);
        wait_drain();

        // asynchronous reset mid-divide
        start_op(1'b0, 1'b1, 32'd12345, -32'sd7, 1'b0);
        repeat (9) @(posedge clock);
        #3 reset = 1'b0;
        exp_q.delete();
        #1;
        check("arst_result", data_result, 32'h0);
        check("arst_exc", {31'b0, data_exception}, 32'h0);
        check("arst_rdy", {31'b0, data_resultRDY}, 32'h0);
        check("arst_busy", {31'b0, busy}, 32'h0);
        @(negedge clock) reset = 1'b1;
        repeat (40) @(posedge clock);
        start_op(1'b1, 1'b0, 32'd2, 32'd2, 1'b0);
        wait_drain();

        for (int i = 0; i < 8; i++) begin
            start_op(i[0], ~i[0], $urandom, (i == 3) ? 32'hFFFF_FFF0 : $urandom_range(1, 500), 1'b0);
            wait_drain();
        end

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
